// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv
// Description : Clocked EX-stage ALU with a start/done handshake. Single-cycle
//               logic, shift, compare and branch ops register their result at
//               the start edge. Iterative multiply (radix-2 shift-add) and
//               restoring divide write HI/LO and take DWIDTH+2 cycles.
// Ports       : a_i_clk/a_i_rst      clock, asynchronous active-high reset
//               a_i_start/a_i_funct  request pulse and operation code
//               a_i_data_rs/rt       operands A and B (B also shift source)
//               a_i_imm/a_i_alu_src  immediate ([10:6] = shamt), B select
//               a_i_pc               PC of the instruction
//               alu_value/alu_pc     registered result and next PC
//               alu_zero             registered (alu_value == 0)
//               alu_div_zero         last completed op was a divide by zero
//               alu_busy/done        op in flight / one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv #(
    parameter int DWIDTH    = 32,
    parameter int IMM_WIDTH = 16,
    parameter int PC_WIDTH  = 32
) (
    input  logic                 a_i_clk,
    input  logic                 a_i_rst,
    input  logic                 a_i_start,
    input  logic [4:0]           a_i_funct,
    input  logic [DWIDTH-1:0]    a_i_data_rs,
    input  logic [DWIDTH-1:0]    a_i_data_rt,
    input  logic [IMM_WIDTH-1:0] a_i_imm,
    input  logic                 a_i_alu_src,
    input  logic [PC_WIDTH-1:0]  a_i_pc,
    output logic [DWIDTH-1:0]    alu_value,
    output logic [PC_WIDTH-1:0]  alu_pc,
    output logic                 alu_zero,
    output logic                 alu_div_zero,
    output logic                 alu_busy,
    output logic                 done
);
    localparam int CNT_W = $clog2(DWIDTH + 1);

    localparam logic [4:0] F_ADD  = 5'd0,  F_SUB   = 5'd1,  F_AND  = 5'd2,  F_OR   = 5'd3;
    localparam logic [4:0] F_XOR  = 5'd4,  F_NOR   = 5'd5,  F_SLT  = 5'd6,  F_SLTU = 5'd7;
    localparam logic [4:0] F_SLL  = 5'd8,  F_SRL   = 5'd9,  F_SRA  = 5'd10, F_BEQ  = 5'd11;
    localparam logic [4:0] F_BNE  = 5'd12, F_MULT  = 5'd16, F_MULTU = 5'd17;
    localparam logic [4:0] F_DIV  = 5'd18, F_DIVU  = 5'd19, F_MFHI = 5'd20, F_MFLO = 5'd21;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                state_q,    state_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic [2*DWIDTH-1:0]   acc_q,      acc_d;      // MUL: {partial, multiplier}; DIV: {remainder, dividend/quotient}
    logic [DWIDTH-1:0]     opb_q,      opb_d;      // multiplicand / divisor magnitude
    logic                  is_div_q,   is_div_d;
    logic                  neg_q,      neg_d;      // negate product / quotient
    logic                  neg_rem_q,  neg_rem_d;  // negate remainder
    logic                  dz_q,       dz_d;       // divide-by-zero op pending
    logic [DWIDTH-1:0]     hi_q,       hi_d;
    logic [DWIDTH-1:0]     lo_q,       lo_d;
    logic [DWIDTH-1:0]     value_q,    value_d;
    logic [PC_WIDTH-1:0]   pc_q,       pc_d;
    logic [PC_WIDTH-1:0]   pc_pend_q,  pc_pend_d;  // next PC held until the multi-cycle op completes
    logic                  zero_q,     zero_d;
    logic                  div_zero_q, div_zero_d;

    // Operand selection and helpers
    logic [DWIDTH-1:0]   w_imm_sext, w_opb, w_a_mag, w_b_mag, w_result;
    logic [PC_WIDTH-1:0] w_pc_seq, w_pc_br;
    logic [4:0]          w_shamt;
    logic                w_signed, w_a_neg, w_b_neg, w_taken, w_accept;

    assign w_imm_sext = DWIDTH'($signed(a_i_imm));
    assign w_opb      = a_i_alu_src ? w_imm_sext : a_i_data_rt;
    assign w_shamt    = a_i_imm[10:6];
    assign w_signed   = (a_i_funct == F_MULT) || (a_i_funct == F_DIV);
    assign w_a_neg    = w_signed & a_i_data_rs[DWIDTH-1];
    assign w_b_neg    = w_signed & w_opb[DWIDTH-1];
    assign w_a_mag    = w_a_neg ? (~a_i_data_rs + 1'b1) : a_i_data_rs;
    assign w_b_mag    = w_b_neg ? (~w_opb + 1'b1) : w_opb;
    assign w_pc_seq   = a_i_pc + PC_WIDTH'(4);
    assign w_pc_br    = w_pc_seq + (PC_WIDTH'($signed(a_i_imm)) << 2);
    assign w_accept   = a_i_start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Iteration datapaths
    logic [DWIDTH:0]     w_mul_sum, w_div_shift;
    logic [DWIDTH-1:0]   w_div_rem, w_quo, w_rem;
    logic [2*DWIDTH-1:0] w_prod;
    logic                w_div_ge;

    assign w_mul_sum   = {1'b0, acc_q[2*DWIDTH-1:DWIDTH]} + (acc_q[0] ? {1'b0, opb_q} : {(DWIDTH+1){1'b0}});
    assign w_div_shift = {acc_q[2*DWIDTH-1:DWIDTH], acc_q[DWIDTH-1]};
    assign w_div_ge    = w_div_shift >= {1'b0, opb_q};
    // The true difference is below the divisor, so DWIDTH bits hold it exactly.
    assign w_div_rem   = w_div_shift[DWIDTH-1:0] - opb_q;
    assign w_prod      = neg_q ? (~acc_q + 1'b1) : acc_q;
    assign w_quo       = neg_q ? (~acc_q[DWIDTH-1:0] + 1'b1) : acc_q[DWIDTH-1:0];
    assign w_rem       = neg_rem_q ? (~acc_q[2*DWIDTH-1:DWIDTH] + 1'b1) : acc_q[2*DWIDTH-1:DWIDTH];

    // Single-cycle result
    always_comb begin
        w_result = '0;
        w_taken  = 1'b0;
        case (a_i_funct)
            F_ADD:   w_result = a_i_data_rs + w_opb;
            F_SUB:   w_result = a_i_data_rs - w_opb;
            F_AND:   w_result = a_i_data_rs & w_opb;
            F_OR:    w_result = a_i_data_rs | w_opb;
            F_XOR:   w_result = a_i_data_rs ^ w_opb;
            F_NOR:   w_result = ~(a_i_data_rs | w_opb);
            F_SLT:   w_result = DWIDTH'($signed(a_i_data_rs) < $signed(w_opb));
            F_SLTU:  w_result = DWIDTH'(a_i_data_rs < w_opb);
            F_SLL:   w_result = a_i_data_rt << w_shamt;
            F_SRL:   w_result = a_i_data_rt >> w_shamt;
            F_SRA:   w_result = DWIDTH'($signed(a_i_data_rt) >>> w_shamt);
            F_BEQ: begin
                w_result = a_i_data_rs - a_i_data_rt;
                w_taken  = (a_i_data_rs == a_i_data_rt);
            end
            F_BNE: begin
                w_result = a_i_data_rs - a_i_data_rt;
                w_taken  = (a_i_data_rs != a_i_data_rt);
            end
            F_MFHI:  w_result = hi_q;
            F_MFLO:  w_result = lo_q;
            default: w_result = '0;
        endcase
    end

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opb_d      = opb_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        neg_rem_d  = neg_rem_q;
        dz_d       = dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        value_d    = value_q;
        pc_d       = pc_q;
        pc_pend_d  = pc_pend_q;
        zero_d     = zero_q;
        div_zero_d = div_zero_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (w_accept) begin
                    div_zero_d = 1'b0;
                    dz_d       = 1'b0;
                    pc_pend_d  = w_pc_seq;
                    case (a_i_funct)
                        F_MULT, F_MULTU: begin
                            acc_d    = {{DWIDTH{1'b0}}, w_a_mag};
                            opb_d    = w_b_mag;
                            is_div_d = 1'b0;
                            neg_d    = w_a_neg ^ w_b_neg;
                            cnt_d    = CNT_W'(DWIDTH);
                            state_d  = S_MUL;
                        end
                        F_DIV, F_DIVU: begin
                            is_div_d  = 1'b1;
                            neg_d     = w_a_neg ^ w_b_neg;
                            neg_rem_d = w_a_neg;
                            if (w_opb == '0) begin
                                // Raw HI=rs, LO=all ones; FIX passes them through unsigned.
                                dz_d    = 1'b1;
                                acc_d   = {a_i_data_rs, {DWIDTH{1'b1}}};
                                state_d = S_FIX;
                            end else begin
                                acc_d   = {{DWIDTH{1'b0}}, w_a_mag};
                                opb_d   = w_b_mag;
                                cnt_d   = CNT_W'(DWIDTH);
                                state_d = S_DIV;
                            end
                        end
                        default: begin
                            value_d = w_result;
                            zero_d  = (w_result == '0);
                            pc_d    = w_taken ? w_pc_br : w_pc_seq;
                            state_d = S_DONE;
                        end
                    endcase
                end
            end
            S_MUL: begin
                acc_d = {w_mul_sum, acc_q[DWIDTH-1:1]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
            S_DIV: begin
                acc_d = w_div_ge ? {w_div_rem, acc_q[DWIDTH-2:0], 1'b1}
                                 : {w_div_shift[DWIDTH-1:0], acc_q[DWIDTH-2:0], 1'b0};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (dz_q) begin
                    hi_d = acc_q[2*DWIDTH-1:DWIDTH];
                    lo_d = acc_q[DWIDTH-1:0];
                end else if (is_div_q) begin
                    hi_d = w_rem;
                    lo_d = w_quo;
                end else begin
                    hi_d = w_prod[2*DWIDTH-1:DWIDTH];
                    lo_d = w_prod[DWIDTH-1:0];
                end
                value_d    = lo_d;
                zero_d     = (lo_d == '0);
                pc_d       = pc_pend_q;
                div_zero_d = dz_q;
                state_d    = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge a_i_clk or posedge a_i_rst) begin
        if (a_i_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            value_q    <= '0;
            pc_q       <= '0;
            pc_pend_q  <= '0;
            zero_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opb_q      <= opb_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            neg_rem_q  <= neg_rem_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            value_q    <= value_d;
            pc_q       <= pc_d;
            pc_pend_q  <= pc_pend_d;
            zero_q     <= zero_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign alu_value    = value_q;
    assign alu_pc       = pc_q;
    assign alu_zero     = zero_q;
    assign alu_div_zero = div_zero_q;
    assign alu_busy     = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    assign done         = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_muldiv
// Description : Scoreboard bench for alu_muldiv. Each issued op pushes the
//               reference result (plain arithmetic on 32-bit operands) into a
//               queue; a monitor pops and compares on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv;
    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  funct = '0;
    logic [31:0] rs = '0, rt = '0, pc = '0;
    logic [15:0] imm = '0;
    logic        src = 1'b0;
    logic [31:0] alu_value, alu_pc;
    logic        alu_zero, alu_div_zero, busy, done;

    alu_muldiv #(.DWIDTH(32), .IMM_WIDTH(16), .PC_WIDTH(32)) dut (
        .a_i_clk(clk), .a_i_rst(rst), .a_i_start(start), .a_i_funct(funct),
        .a_i_data_rs(rs), .a_i_data_rt(rt), .a_i_imm(imm), .a_i_alu_src(src),
        .a_i_pc(pc), .alu_value(alu_value), .alu_pc(alu_pc), .alu_zero(alu_zero),
        .alu_div_zero(alu_div_zero), .alu_busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] value;
        logic [31:0] pc;
        logic        zero;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] m_hi = '0, m_lo = '0;
    int          busy_exp_last = 0;
    int          tests = 0, fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model and driver: computes the expected completion, then pulses start.
    task automatic issue(input logic [4:0] f, input logic [31:0] rs_v, input logic [31:0] rt_v,
                         input logic [15:0] imm_v, input logic src_v, input logic [31:0] pc_v);
        exp_t        e;
        logic [31:0] sx, b, v;
        logic [63:0] p;
        longint      q, r;
        logic        taken;
        int          lat;
        sx = {{16{imm_v[15]}}, imm_v};
        b  = src_v ? sx : rt_v;
        v = '0; taken = 1'b0; lat = 1; e.dz = 1'b0;
        case (f)
            5'd0:  v = rs_v + b;
            5'd1:  v = rs_v - b;
            5'd2:  v = rs_v & b;
            5'd3:  v = rs_v | b;
            5'd4:  v = rs_v ^ b;
            5'd5:  v = ~(rs_v | b);
            5'd6:  v = ($signed(rs_v) < $signed(b)) ? 32'd1 : 32'd0;
            5'd7:  v = (rs_v < b) ? 32'd1 : 32'd0;
            5'd8:  v = rt_v << imm_v[10:6];
            5'd9:  v = rt_v >> imm_v[10:6];
            5'd10: v = $signed(rt_v) >>> imm_v[10:6];
            5'd11: begin v = rs_v - rt_v; taken = (rs_v == rt_v); end
            5'd12: begin v = rs_v - rt_v; taken = (rs_v != rt_v); end
            5'd16: begin
                p = 64'(longint'($signed(rs_v)) * longint'($signed(b)));
                m_hi = p[63:32]; m_lo = p[31:0]; v = m_lo; lat = W + 2;
            end
            5'd17: begin
                p = {32'd0, rs_v} * {32'd0, b};
                m_hi = p[63:32]; m_lo = p[31:0]; v = m_lo; lat = W + 2;
            end
            5'd18, 5'd19: begin
                if (b == 32'd0) begin
                    m_hi = rs_v; m_lo = 32'hFFFF_FFFF; e.dz = 1'b1; lat = 2;
                end else if (f == 5'd18) begin
                    q = longint'($signed(rs_v)) / longint'($signed(b));
                    r = longint'($signed(rs_v)) % longint'($signed(b));
                    m_lo = q[31:0]; m_hi = r[31:0]; lat = W + 2;
                end else begin
                    m_lo = rs_v / b; m_hi = rs_v % b; lat = W + 2;
                end
                v = m_lo;
            end
            5'd20: v = m_hi;
            5'd21: v = m_lo;
            default: v = '0;
        endcase
        e.value = v;
        e.zero  = (v == 32'd0);
        e.pc    = taken ? (pc_v + 32'd4 + (sx << 2)) : (pc_v + 32'd4);
        e.cyc   = cyc + lat;
        busy_exp_last = lat - 1;
        exp_q.push_back(e);
        funct = f; rs = rs_v; rt = rt_v; imm = imm_v; src = src_v; pc = pc_v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        funct = 5'($urandom); rs = $urandom; rt = $urandom; imm = 16'($urandom);
        src = 1'($urandom); pc = $urandom;
    endtask

    // Waits (bounded) for done, counting busy cycles; busy_exp < 0 skips that check.
    task automatic wait_done(input int busy_exp);
        int n = 0;
        int b = 0;
        while (done !== 1'b1 && n < 100) begin
            if (busy === 1'b1) b++;
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            tests++; fails++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
        end else if (busy_exp >= 0) begin
            chk("busy_cycles", 64'(b), 64'(busy_exp));
        end
    endtask

    task automatic run(input logic [4:0] f, input logic [31:0] rs_v, input logic [31:0] rt_v,
                       input logic [15:0] imm_v, input logic src_v, input logic [31:0] pc_v);
        issue(f, rs_v, rt_v, imm_v, src_v, pc_v);
        wait_done(busy_exp_last);
    endtask

    // Monitor: every done pulse consumes exactly one expected completion.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_done: got done=1 expected no completion (t=%0t)", $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("value",      64'(alu_value),    64'(mon_e.value));
                chk("next_pc",    64'(alu_pc),       64'(mon_e.pc));
                chk("zero",       64'(alu_zero),     64'(mon_e.zero));
                chk("div_zero",   64'(alu_div_zero), 64'(mon_e.dz));
                chk("done_cycle", 64'(cyc),          64'(mon_e.cyc));
                chk("busy_at_done", 64'(busy),       64'd0);
            end
        end
    end

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 15));
            1: return 32'(-$urandom_range(1, 16));
            2: return $urandom;
            default: case ($urandom_range(0, 4))
                0: return 32'h8000_0000;
                1: return 32'hFFFF_FFFF;
                2: return 32'h7FFF_FFFF;
                3: return 32'd1;
                default: return 32'd0;
            endcase
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_value", 64'(alu_value), 64'd0);
        chk("reset_pc",    64'(alu_pc),    64'd0);
        chk("reset_zero",  64'(alu_zero),  64'd0);
        chk("reset_busy",  64'(busy),      64'd0);
        chk("reset_done",  64'(done),      64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Immediate and branch
        run(5'd0,  32'd5, 32'd4, 16'h0000, 1'b0, 32'd0);
        run(5'd0,  32'd5, 32'd0, 16'hFFFE, 1'b1, 32'd0);
        run(5'd11, 32'd5, 32'd5, 16'd4,    1'b0, 32'd10);
        run(5'd12, 32'd5, 32'd5, 16'd4,    1'b0, 32'd10);
        run(5'd12, 32'd5, 32'd6, 16'hFFFF, 1'b0, 32'd100);
        // Multiply
        run(5'd16, 32'hFFFF_FFFD, 32'd7, 16'd0, 1'b0, 32'h40);
        run(5'd21, 32'd0, 32'd0, 16'd0, 1'b0, 32'h44);
        run(5'd20, 32'd0, 32'd0, 16'd0, 1'b0, 32'h48);
        run(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'd0, 1'b0, 32'h4C);
        run(5'd20, 32'd0, 32'd0, 16'd0, 1'b0, 32'h50);
        run(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 16'd0, 1'b0, 32'h54);
        run(5'd20, 32'd0, 32'd0, 16'd0, 1'b0, 32'h58);
        // Divide
        run(5'd18, 32'hFFFF_FFF9, 32'd2, 16'd0, 1'b0, 32'h60);
        run(5'd20, 32'd0, 32'd0, 16'd0, 1'b0, 32'h64);
        run(5'd19, 32'd100, 32'd7, 16'd0, 1'b0, 32'h68);
        run(5'd20, 32'd0, 32'd0, 16'd0, 1'b0, 32'h6C);
        run(5'd18, 32'h8000_0000, 32'hFFFF_FFFF, 16'd0, 1'b0, 32'h70);
        run(5'd20, 32'd0, 32'd0, 16'd0, 1'b0, 32'h74);
        run(5'd18, 32'd9, 32'd0, 16'd0, 1'b0, 32'h78);
        run(5'd20, 32'd0, 32'd0, 16'd0, 1'b0, 32'h7C);
        run(5'd21, 32'd0, 32'd0, 16'd0, 1'b0, 32'h80);
        // Shifts, compares, illegal code
        run(5'd10, 32'd0, 32'h8000_0000, 16'h0100, 1'b0, 32'h84);
        run(5'd6,  32'hFFFF_FFFF, 32'd1, 16'd0, 1'b0, 32'h88);
        run(5'd7,  32'hFFFF_FFFF, 32'd1, 16'd0, 1'b0, 32'h8C);
        run(5'd31, 32'd3, 32'd4, 16'd0, 1'b0, 32'h90);

        // Start pulsed while a divide is in flight is ignored
        issue(5'd19, 32'd100, 32'd7, 16'd0, 1'b0, 32'hA0);
        repeat (4) @(negedge clk);
        funct = 5'd0; rs = 32'd1; rt = 32'd1; src = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(-1);

        // Asynchronous reset in the middle of a multiply
        issue(5'd16, 32'hFFFF_FFFD, 32'd7, 16'd0, 1'b0, 32'hB0);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy",  64'(busy),      64'd0);
        chk("rst_done",  64'(done),      64'd0);
        chk("rst_value", 64'(alu_value), 64'd0);
        chk("rst_pc",    64'(alu_pc),    64'd0);
        exp_q.delete();
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        chk("rst_no_done", 64'(done), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        run(5'd20, 32'd0, 32'd0, 16'd0, 1'b0, 32'hC0);
        run(5'd21, 32'd0, 32'd0, 16'd0, 1'b0, 32'hC4);
        run(5'd0,  32'd5, 32'd4, 16'd0, 1'b0, 32'hC8);

        // Randomized ops, back-to-back or with idle gaps
        for (int i = 0; i < 80; i++) begin
            logic [4:0] f;
            f = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(22, 31)) : 5'($urandom_range(0, 21));
            run(f, rnd_val(), rnd_val(), 16'($urandom), 1'($urandom_range(0, 3) == 0), $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
